// File: rtl/msrv32_integer_file.sv
// RV32I integer register file: x1..x31 storage, x0 hardwired to zero.
// Two combinational operand read ports with same-cycle write forwarding,
// plus a non-forwarding debug read port that observes storage only.
module msrv32_integer_file #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  ms_riscv32_mp_clk_in,
    input  logic                  ms_riscv32_mp_rst_in,
    input  logic [ADDR_WIDTH-1:0] rs_1_addr_in,
    input  logic [ADDR_WIDTH-1:0] rs_2_addr_in,
    input  logic [ADDR_WIDTH-1:0] rd_addr_in,
    input  logic                  wr_en_in,
    input  logic                  flush_in,
    input  logic [WIDTH-1:0]      rd_in,
    input  logic [ADDR_WIDTH-1:0] dbg_addr_in,
    output logic [WIDTH-1:0]      rs_1_out,
    output logic [WIDTH-1:0]      rs_2_out,
    output logic [WIDTH-1:0]      dbg_data_out
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // x0 has no storage; entries start at index 1.
    logic [WIDTH-1:0] r_regs [1:DEPTH-1];
    logic             w_we;

    // Effective write enable: squashed by flush, reset, or a write to x0.
    always_comb begin
        w_we = wr_en_in & ~flush_in & ~ms_riscv32_mp_rst_in & (rd_addr_in != '0);
    end

    // Storage update: synchronous clear on reset, otherwise single-port write.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[rd_addr_in] <= rd_in;
        end
    end

    // Operand read ports: zero for x0, forward the in-flight write, else storage.
    always_comb begin
        rs_1_out = '0;
        rs_2_out = '0;
        if (!ms_riscv32_mp_rst_in) begin
            if (rs_1_addr_in != '0) begin
                rs_1_out = (w_we && rs_1_addr_in == rd_addr_in) ? rd_in : r_regs[rs_1_addr_in];
            end
            if (rs_2_addr_in != '0) begin
                rs_2_out = (w_we && rs_2_addr_in == rd_addr_in) ? rd_in : r_regs[rs_2_addr_in];
            end
        end
    end

    // Debug read port: storage only, never forwarded.
    always_comb begin
        dbg_data_out = '0;
        if (!ms_riscv32_mp_rst_in && dbg_addr_in != '0) begin
            dbg_data_out = r_regs[dbg_addr_in];
        end
    end

endmodule

// File: tb/tb_msrv32_integer_file.sv
// Scoreboard bench for msrv32_integer_file: stimulus pushes expected port
// values tagged with the cycle they apply to; a negedge monitor pops and checks.
module tb_msrv32_integer_file;

    logic        clk;
    logic        rst;
    logic [4:0]  a1, a2, rd, ad;
    logic        wen, flush;
    logic [31:0] din;
    logic [31:0] q1, q2, qd;

    msrv32_integer_file #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .rs_1_addr_in         (a1),
        .rs_2_addr_in         (a2),
        .rd_addr_in           (rd),
        .wr_en_in             (wen),
        .flush_in             (flush),
        .rd_in                (din),
        .dbg_addr_in          (ad),
        .rs_1_out             (q1),
        .rs_2_out             (q2),
        .dbg_data_out         (qd)
    );

    typedef struct {
        int          cyc;
        int          port;   // 0 = rs_1, 1 = rs_2, 2 = dbg
        logic [31:0] exp;
        string       name;
    } sb_t;

    sb_t sb[$];
    int  cyc     = 0;
    int  n_cmp   = 0;
    int  n_err   = 0;
    sb_t         m_e;
    logic [31:0] m_act;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: compare every expectation due this cycle against the live outputs.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m_e = sb.pop_front();
            case (m_e.port)
                0:       m_act = q1;
                1:       m_act = q2;
                default: m_act = qd;
            endcase
            n_cmp++;
            if (m_e.cyc != cyc || m_act !== m_e.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                         m_e.name, m_act, m_e.exp, cyc, m_e.cyc);
            end
        end
    end

    // Apply one cycle of inputs shortly after the rising edge.
    task automatic drive(input logic r, input logic w, input logic f,
                         input logic [4:0] rda, input logic [31:0] d,
                         input logic [4:0] ra1, input logic [4:0] ra2,
                         input logic [4:0] rad);
        @(posedge clk);
        #1;
        rst = r; wen = w; flush = f; rd = rda; din = d;
        a1 = ra1; a2 = ra2; ad = rad;
    endtask

    task automatic expect_val(input int port, input logic [31:0] v, input string name);
        sb_t e;
        e.cyc  = cyc;
        e.port = port;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; flush = 1'b0; rd = '0; din = '0;
        a1 = '0; a2 = '0; ad = '0;

        // Reset: outputs forced to zero while asserted, storage clear afterwards.
        drive(1, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
        expect_val(0, 32'h0, "rst_rs1");
        expect_val(1, 32'h0, "rst_rs2");
        expect_val(2, 32'h0, "rst_dbg");
        drive(0, 0, 0, 0, 0, 5'd1, 5'd31, 5'd17);
        expect_val(0, 32'h0, "post_rst_x1");
        expect_val(1, 32'h0, "post_rst_x31");
        expect_val(2, 32'h0, "post_rst_dbg_x17");

        // Test 1: write x5, then reset clears it.
        drive(0, 1, 0, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 5'd5);
        expect_val(0, 32'hDEAD_BEEF, "t1_fwd_x5");
        expect_val(2, 32'h0, "t1_dbg_x5_before");
        drive(1, 0, 0, 0, 0, 5'd5, 5'd5, 5'd5);
        expect_val(0, 32'h0, "t1_during_rst_rs1");
        expect_val(2, 32'h0, "t1_during_rst_dbg");
        // Reset priority over a simultaneous write to x6.
        drive(1, 1, 0, 5'd6, 32'h77, 5'd6, 5'd5, 5'd6);
        expect_val(0, 32'h0, "rstw_rs1_x6");
        drive(0, 0, 0, 0, 0, 5'd5, 5'd6, 5'd6);
        expect_val(0, 32'h0, "t1_x5_cleared");
        expect_val(1, 32'h0, "rstw_x6_dropped");
        expect_val(2, 32'h0, "rstw_dbg_x6");

        // Test 2: write x1, read on all ports next cycle.
        drive(0, 1, 0, 5'd1, 32'h1234_5678, 5'd0, 5'd0, 5'd1);
        expect_val(2, 32'h0, "t2_dbg_before");
        drive(0, 0, 0, 0, 0, 5'd1, 5'd1, 5'd1);
        expect_val(0, 32'h1234_5678, "t2_rs1_x1");
        expect_val(1, 32'h1234_5678, "t2_rs2_x1");
        expect_val(2, 32'h1234_5678, "t2_dbg_x1");

        // Test 3: writes to x0 are discarded.
        drive(0, 1, 0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        expect_val(0, 32'h0, "t3_rs1_x0_same");
        expect_val(1, 32'h0, "t3_rs2_x0_same");
        expect_val(2, 32'h0, "t3_dbg_x0");
        drive(0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd0);
        expect_val(0, 32'h0, "t3_rs1_x0_next");
        expect_val(1, 32'h1234_5678, "t3_x1_intact");

        // Test 4: forwarding on both ports, debug not forwarded.
        drive(0, 1, 0, 5'd7, 32'hA, 5'd0, 5'd0, 5'd0);
        drive(0, 1, 0, 5'd7, 32'hB, 5'd7, 5'd7, 5'd7);
        expect_val(0, 32'hB, "t4_fwd_rs1");
        expect_val(1, 32'hB, "t4_fwd_rs2");
        expect_val(2, 32'hA, "t4_dbg_old");
        drive(0, 0, 0, 0, 0, 5'd7, 5'd0, 5'd7);
        expect_val(0, 32'hB, "t4_rs1_stored");
        expect_val(2, 32'hB, "t4_dbg_new");

        // Test 5: flush suppresses write and forwarding.
        drive(0, 1, 0, 5'd9, 32'h55, 5'd0, 5'd0, 5'd0);
        drive(0, 1, 1, 5'd9, 32'hAA, 5'd9, 5'd9, 5'd9);
        expect_val(0, 32'h55, "t5_rs1_flush");
        expect_val(1, 32'h55, "t5_rs2_flush");
        expect_val(2, 32'h55, "t5_dbg_flush");
        drive(0, 0, 0, 0, 0, 5'd0, 5'd9, 5'd9);
        expect_val(1, 32'h55, "t5_rs2_next");
        expect_val(2, 32'h55, "t5_dbg_next");

        // Back-to-back writes to x3: each forwarded, last wins.
        drive(0, 1, 0, 5'd3, 32'h1, 5'd3, 5'd0, 5'd3);
        expect_val(0, 32'h1, "b2b_fwd1");
        drive(0, 1, 0, 5'd3, 32'h2, 5'd3, 5'd0, 5'd3);
        expect_val(0, 32'h2, "b2b_fwd2");
        expect_val(2, 32'h1, "b2b_dbg1");
        drive(0, 0, 0, 0, 0, 5'd3, 5'd0, 5'd3);
        expect_val(0, 32'h2, "b2b_last");
        expect_val(2, 32'h2, "b2b_dbg_last");

        // Test 6: sweep all registers, read mirrored pairs.
        for (int i = 1; i < 32; i++) begin
            drive(0, 1, 0, 5'(i), 32'(i) * 32'h0101_0101, 5'd0, 5'd0, 5'd0);
        end
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 0, 5'(i), 5'(31 - i), 5'(i));
            expect_val(0, 32'(i) * 32'h0101_0101, $sformatf("sw_rs1_x%0d", i));
            expect_val(1, 32'(31 - i) * 32'h0101_0101, $sformatf("sw_rs2_x%0d", 31 - i));
            expect_val(2, 32'(i) * 32'h0101_0101, $sformatf("sw_dbg_x%0d", i));
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
